// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : IDLE/RUN/HALT instruction fetch stage with branch, stall and
// halt-word detection; cycle counter present only with FETCH_CYCLE_COUNT_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter logic [7:0] PC_RESET  = 8'd0,
  parameter logic [8:0] HALT_INST = 9'b111_111_111
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [7:0]  pc,
  input  logic [8:0]  inst_in,
  output logic [8:0]  inst_out,
  output logic [7:0]  inst_pc,
  output logic        inst_valid,
  output logic        done,
  output logic        halted,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_restart;
  logic        w_branch;
  logic        w_halt;
  logic        w_fetch;

  logic [7:0]  r_pc;
  logic [8:0]  r_inst_out;
  logic [7:0]  r_inst_pc;
  logic        r_inst_valid;
  logic        r_done;
  logic        r_halted;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Priority inside RUN: branch, then stall, then halt detection.
  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_branch     = 1'b0;
    w_halt       = 1'b0;
    w_fetch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_RUN;
          w_restart    = 1'b1;
        end
      end
      S_RUN: begin
        if (branch_taken) begin
          w_branch = 1'b1;
        end else if (!stall) begin
          if (inst_in == HALT_INST) begin
            w_halt       = 1'b1;
            w_next_state = S_HALT;
          end else begin
            w_fetch = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          w_next_state = S_RUN;
          w_restart    = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_pc         <= PC_RESET;
      r_inst_out   <= 9'd0;
      r_inst_pc    <= 8'd0;
      r_inst_valid <= 1'b0;
      r_done       <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_done   <= w_halt;
      r_halted <= (w_next_state == S_HALT);
      if (w_restart) begin
        r_pc         <= PC_RESET;
        r_inst_valid <= 1'b0;
      end else if (w_branch) begin
        r_pc         <= branch_target;
        r_inst_valid <= 1'b0;
      end else if (w_halt) begin
        r_inst_valid <= 1'b0;
      end else if (w_fetch) begin
        r_inst_out   <= inst_in;
        r_inst_pc    <= r_pc;
        r_inst_valid <= 1'b1;
        r_pc         <= r_pc + 8'd1;
      end
    end
  end

  assign pc         = r_pc;
  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;
  assign done       = r_done;
  assign halted     = r_halted;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] r_cycle_count;

  // Counts every RUN cycle, including stalled, branch and halting cycles.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cycle_count <= 16'd0;
    end else if (w_restart) begin
      r_cycle_count <= 16'd0;
    end else if ((r_state == S_RUN) && (r_cycle_count != 16'hFFFF)) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed and randomized stimulus for fetch_unit against a
// cycle-level reference model. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam logic [7:0] PC_RESET  = 8'd0;
  localparam logic [8:0] HALT_INST = 9'b111_111_111;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  pc;
  logic [8:0]  inst_in;
  logic [8:0]  inst_out;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        done;
  logic        halted;
  logic [15:0] cycle_count;

  logic [8:0]  rom [256];

  fetch_unit #(
    .PC_RESET  (PC_RESET),
    .HALT_INST (HALT_INST)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .inst_in       (inst_in),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .done          (done),
    .halted        (halted),
    .cycle_count   (cycle_count)
  );

  assign inst_in = rom[pc];

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = idle, 1 = running, 2 = halted.
  int         m_mode;
  logic [7:0] m_pc;
  logic [8:0] m_iout;
  logic [7:0] m_ipc;
  bit         m_valid;
  bit         m_done;
  int         m_cnt;

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = PC_RESET;
    m_iout  = 9'd0;
    m_ipc   = 8'd0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input bit st, input bit stl, input bit br, input logic [7:0] bt);
    logic [8:0] word;
    word   = rom[m_pc];
    m_done = 1'b0;
    if (m_mode == 0) begin
      if (st) begin
        m_mode = 1;
        m_cnt  = 0;
      end
    end else if (m_mode == 1) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (br) begin
        m_pc    = bt;
        m_valid = 1'b0;
      end else if (!stl) begin
        if (word == HALT_INST) begin
          m_mode  = 2;
          m_valid = 1'b0;
          m_done  = 1'b1;
        end else begin
          m_iout  = word;
          m_ipc   = m_pc;
          m_valid = 1'b1;
          m_pc    = 8'((int'(m_pc) + 1) % 256);
        end
      end
    end else begin
      if (st) begin
        m_mode  = 1;
        m_pc    = PC_RESET;
        m_cnt   = 0;
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_cnt;
`ifdef FETCH_CYCLE_COUNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("pc",          16'(pc),          16'(m_pc));
    chk("inst_out",    16'(inst_out),    16'(m_iout));
    chk("inst_pc",     16'(inst_pc),     16'(m_ipc));
    chk("inst_valid",  16'(inst_valid),  16'(m_valid));
    chk("done",        16'(done),        16'(m_done));
    chk("halted",      16'(halted),      16'(m_mode == 2));
    chk("cycle_count", 16'(cycle_count), 16'(exp_cnt));
  endtask

  task automatic cycle(input bit st, input bit stl, input bit br, input logic [7:0] bt);
    start         = st;
    stall         = stl;
    branch_taken  = br;
    branch_target = bt;
    @(posedge CLK);
    if (reset) model_reset();
    else       model_step(st, stl, br, bt);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(0, 510));
    rom[11] = HALT_INST;

    reset = 1'b1; start = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 8'd0;
    model_reset();
    #1;
    check_all();
    // start and branch while held in reset must do nothing
    cycle(1'b1, 1'b0, 1'b1, 8'd77);
    #2 reset = 1'b0;

    // start, then sequential fetch 0..2
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'd0);
    // stall 3 cycles at pc = 2 (branch idle, start in RUN ignored)
    cycle(1'b0, 1'b1, 1'b0, 8'd0);
    cycle(1'b1, 1'b1, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'd0);
    // advance to pc = 5, then branch to 40 (branch beats stall)
    cycle(1'b0, 1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 1'b1, 8'd40);
    cycle(1'b0, 1'b0, 1'b0, 8'd0);
    // branch to 8 and run into the halt word at 11
    cycle(1'b0, 1'b0, 1'b1, 8'd8);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0);
    // HALT ignores stall and branch
    cycle(1'b0, 1'b1, 1'b1, 8'd99);
    cycle(1'b0, 1'b0, 1'b1, 8'd3);
    // restart from HALT
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    // wrap 0xFF -> 0x00
    cycle(1'b0, 1'b0, 1'b1, 8'hFF);
    cycle(1'b0, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0);

    // asynchronous reset at pc = 7, observed before the next edge
    chk("pc_before_reset", 16'(pc), 16'd7);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b0;
    // idle ignores stall/branch; first start after reset is honoured
    cycle(1'b0, 1'b1, 1'b1, 8'd50);
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'd0);

    // randomized phase with a fresh ROM containing sparse halt words
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 15) == 0) ? HALT_INST : 9'($urandom_range(0, 510));
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 7) == 0),
            bit'($urandom_range(0, 3) == 0),
            bit'($urandom_range(0, 7) == 0),
            8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
